cve2_wb_stage: RTL and testbench
================================

# cve2_wb_stage

Registered writeback stage for the cve2 core. It replaces the combinational ID-to-register-file passthrough with a single-entry pipeline register. That register holds each retiring instruction for one cycle, or until its LSU response arrives. It routes the result to one of `NumRf` register files and produces retire pulses for the performance counters. It sits between the ID/EX stage and the register files, and exposes its entry for hazard and forwarding logic in ID.

## Interface
Parameters:
- `NumRf`, 2, number of register files targeted (0 = integer, 1 = FP); must be ≥1
- `DataWidth`, 32, write data width
- `AddrWidth`, 5, register address width
- `SelWidth`, derived: `NumRf>1 ? $clog2(NumRf) : 1`

Ports (one clock; reset is asynchronous and active-high):
- `clk_i` in 1: clock
- `rst_i` in 1: asynchronous active-high reset
- `en_wb_i` in 1: ID presents a retiring instruction
- `ready_wb_o` out 1: stage can accept this cycle
- `flush_i` in 1: kill a non-LSU entry
- `instr_lsu_id_i` in 1: instruction waits for an LSU response (load or store)
- `instr_is_compressed_id_i` in 1: compressed instruction
- `instr_perf_count_id_i` in 1: count this instruction at retire
- `rf_sel_id_i` in SelWidth: target register file index
- `rf_waddr_id_i` in AddrWidth: destination register
- `rf_wdata_id_i` in DataWidth: ALU/CSR result
- `rf_we_id_i` in 1: instruction writes a register
- `lsu_resp_valid_i` in 1: LSU response valid
- `lsu_resp_err_i` in 1: LSU response is a bus error
- `rf_wdata_lsu_i` in DataWidth: load data
- `rf_waddr_wb_o` out AddrWidth: write address
- `rf_wdata_wb_o` out DataWidth: write data
- `rf_we_wb_o` out NumRf: one-hot write enable per register file
- `wb_valid_o` out 1: entry occupied (for hazard checks)
- `wb_sel_o` out SelWidth: register file index of the entry
- `wb_pending_lsu_o` out 1: entry waiting for LSU data
- `perf_instr_ret_wb_o` out 1: instruction retired
- `perf_instr_ret_compressed_wb_o` out 1: compressed instruction retired

## Operation
- States: `WB_EMPTY`, `WB_FULL` (result held), `WB_WAIT_LSU` (response outstanding).
- Accept: `acc = en_wb_i & ready_wb_o`. On accept, latch sel, waddr, wdata, we, compressed and perf_count. Next state is `WB_WAIT_LSU` if `instr_lsu_id_i`, otherwise `WB_FULL`.
- `ready_wb_o` = 1 in `WB_EMPTY` and `WB_FULL`. In `WB_WAIT_LSU` it equals `lsu_resp_valid_i`.
- Retire happens:
  - in `WB_FULL`: every cycle, unless `flush_i` is high;
  - in `WB_WAIT_LSU`: on `lsu_resp_valid_i`.
- On retire without accept the next state is `WB_EMPTY`. On accept the entry is overwritten by the new instruction.
- Write:
  - `rf_we_wb_o[k] = retire & we_q & (sel_q==k) & ~(lsu_wait & lsu_resp_err_i)`.
  - Data is `wdata_q` in `WB_FULL` and `rf_wdata_lsu_i` in `WB_WAIT_LSU`.
  - `rf_wdata_wb_o` is zero when no enable is set.
- Perf:
  - `perf_instr_ret_wb_o = retire & perf_q & ~(lsu_wait & lsu_resp_err_i)`.
  - The compressed pulse is `perf_instr_ret_wb_o` ANDed with the latched compressed bit.
- Flush:
  - In `WB_FULL`: drops the entry with no write and no perf pulse. A same-cycle accept is still taken.
  - In `WB_WAIT_LSU`: ignored, because the bus transaction is already issued.
  - In `WB_EMPTY`: no effect.
- `lsu_resp_valid_i` outside `WB_WAIT_LSU` is ignored and flagged by an assertion.
- `rf_sel_id_i ≥ NumRf` gives no write; an assertion fires.

## Timing
- Latency: one cycle from accept to write for non-LSU instructions. For LSU instructions the write happens in the response cycle, which is ≥1 cycle after accept.
- Back-to-back: one instruction per cycle is sustained through `WB_FULL`.
- A response and a new accept in the same cycle are both serviced: write the old entry, latch the new one.
- Reset (async, `rst_i`=1):
  - state goes to `WB_EMPTY` and all entry registers clear to 0;
  - outputs read `ready_wb_o`=1, everything else 0;
  - a reset during `WB_WAIT_LSU` drops the entry with no write.
- `wb_valid_o` = state != `WB_EMPTY`. `wb_pending_lsu_o` = state == `WB_WAIT_LSU`. All outputs are combinational from the state plus the current-cycle LSU inputs.

## Structure
- `cve2_pkg` gains the `wb_state_e` enum (`WB_EMPTY`, `WB_FULL`, `WB_WAIT_LSU`).
- Single module; no sub-module needed.
- Assertions:
  - `rf_we_wb_o` is `$onehot0`;
  - no accept while `ready_wb_o`=0;
  - `rf_sel` is in range;
  - no unexpected LSU response.

## Test plan
- Non-LSU stream: accept `{sel=0, waddr=5, wdata=0xDEADBEEF, we=1}` at cycle 0, then `waddr=6` at cycle 1. Expect `rf_we_wb_o=2'b01`, `rf_waddr_wb_o=5`, data `0xDEADBEEF` at cycle 1, then waddr 6 at cycle 2, with one perf pulse each cycle.
- Load with 3-cycle response: accept `sel=1, waddr=3`. Expect `ready_wb_o=0` and `wb_pending_lsu_o=1` until `lsu_resp_valid_i`. Then `rf_we_wb_o=2'b10` with the LSU data `0x12345678`, and `ready_wb_o=1` in that cycle.
- LSU error: load response with `lsu_resp_err_i=1`. Expect no write enable and no perf pulse, and state returns to `WB_EMPTY`.
- Flush: `flush_i` in `WB_FULL` gives no write or perf. `flush_i` in `WB_WAIT_LSU` is ignored and the later response still writes.
- Response plus accept in the same cycle: the old load writes while the new instruction is latched, and writes on the next cycle.
- Reset asserted in `WB_WAIT_LSU`: outputs go to 0 immediately and `ready_wb_o`=1. A later stray response produces no write.

Source files
------------

// File: rtl/cve2_pkg.sv
// Shared cve2 types used by the writeback stage.
package cve2_pkg;

  typedef enum logic [1:0] {
    WB_EMPTY    = 2'd0,
    WB_FULL     = 2'd1,
    WB_WAIT_LSU = 2'd2
  } wb_state_e;

endpackage

// File: rtl/cve2_wb_stage_if.sv
// ID/LSU <-> writeback stage <-> register file signal bundle.
interface cve2_wb_stage_if #(
  parameter int NumRf     = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5,
  parameter int SelWidth  = (NumRf > 1) ? $clog2(NumRf) : 1
);
  logic                 en_wb_i;
  logic                 ready_wb_o;
  logic                 flush_i;
  logic                 instr_lsu_id_i;
  logic                 instr_is_compressed_id_i;
  logic                 instr_perf_count_id_i;
  logic [SelWidth-1:0]  rf_sel_id_i;
  logic [AddrWidth-1:0] rf_waddr_id_i;
  logic [DataWidth-1:0] rf_wdata_id_i;
  logic                 rf_we_id_i;
  logic                 lsu_resp_valid_i;
  logic                 lsu_resp_err_i;
  logic [DataWidth-1:0] rf_wdata_lsu_i;
  logic [AddrWidth-1:0] rf_waddr_wb_o;
  logic [DataWidth-1:0] rf_wdata_wb_o;
  logic [NumRf-1:0]     rf_we_wb_o;
  logic                 wb_valid_o;
  logic [SelWidth-1:0]  wb_sel_o;
  logic                 wb_pending_lsu_o;
  logic                 perf_instr_ret_wb_o;
  logic                 perf_instr_ret_compressed_wb_o;

  // Core side: ID/EX, LSU and the register files.
  modport master (
    output en_wb_i, flush_i, instr_lsu_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_sel_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
    input  ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o, wb_valid_o, wb_sel_o,
           wb_pending_lsu_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
  );

  modport slave (
    input  en_wb_i, flush_i, instr_lsu_id_i, instr_is_compressed_id_i, instr_perf_count_id_i,
           rf_sel_id_i, rf_waddr_id_i, rf_wdata_id_i, rf_we_id_i,
           lsu_resp_valid_i, lsu_resp_err_i, rf_wdata_lsu_i,
    output ready_wb_o, rf_waddr_wb_o, rf_wdata_wb_o, rf_we_wb_o, wb_valid_o, wb_sel_o,
           wb_pending_lsu_o, perf_instr_ret_wb_o, perf_instr_ret_compressed_wb_o
  );
endinterface

// File: rtl/cve2_wb_stage.sv
// Single-entry registered writeback stage: holds a retiring instruction for one
// cycle (or until its LSU response) and routes the result to one of NumRf files.
module cve2_wb_stage
  import cve2_pkg::*;
#(
  parameter int NumRf     = 2,
  parameter int DataWidth = 32,
  parameter int AddrWidth = 5
) (
  input  logic           clk_i,
  input  logic           rst_i,
  cve2_wb_stage_if.slave wb
);
  localparam int SelWidth = (NumRf > 1) ? $clog2(NumRf) : 1;

  wb_state_e            state_q, state_d;
  logic [SelWidth-1:0]  sel_q;
  logic [AddrWidth-1:0] waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic                 we_q, compressed_q, perf_q;

  logic                 acc, lsu_wait, retire, err_kill, write_ok;
  logic [NumRf-1:0]     we_vec;

  assign lsu_wait = (state_q == WB_WAIT_LSU);
  assign wb.ready_wb_o = ~lsu_wait | wb.lsu_resp_valid_i;
  assign acc      = wb.en_wb_i & wb.ready_wb_o;
  assign retire   = ((state_q == WB_FULL) & ~wb.flush_i) | (lsu_wait & wb.lsu_resp_valid_i);
  // A bus error retires the entry but suppresses both its write and its perf count.
  assign err_kill = lsu_wait & wb.lsu_resp_err_i;
  assign write_ok = retire & we_q & ~err_kill;

  always_comb begin
    we_vec = '0;
    for (int k = 0; k < NumRf; k++) begin
      we_vec[k] = write_ok & (sel_q == SelWidth'(k));
    end
  end

  assign wb.rf_we_wb_o    = we_vec;
  assign wb.rf_wdata_wb_o = (|we_vec) ? (lsu_wait ? wb.rf_wdata_lsu_i : wdata_q) : '0;
  assign wb.rf_waddr_wb_o = waddr_q;
  assign wb.wb_valid_o    = (state_q != WB_EMPTY);
  assign wb.wb_sel_o      = sel_q;
  assign wb.wb_pending_lsu_o               = lsu_wait;
  assign wb.perf_instr_ret_wb_o            = retire & perf_q & ~err_kill;
  assign wb.perf_instr_ret_compressed_wb_o = wb.perf_instr_ret_wb_o & compressed_q;

  // Retire and flush in WB_FULL both empty the entry; an accept always overrides.
  always_comb begin
    state_d = state_q;
    if (acc) begin
      state_d = wb.instr_lsu_id_i ? WB_WAIT_LSU : WB_FULL;
    end else if (retire || (state_q == WB_FULL)) begin
      state_d = WB_EMPTY;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= WB_EMPTY;
      sel_q        <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      compressed_q <= 1'b0;
      perf_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        sel_q        <= wb.rf_sel_id_i;
        waddr_q      <= wb.rf_waddr_id_i;
        wdata_q      <= wb.rf_wdata_id_i;
        we_q         <= wb.rf_we_id_i;
        compressed_q <= wb.instr_is_compressed_id_i;
        perf_q       <= wb.instr_perf_count_id_i;
      end
    end
  end

`ifndef SYNTHESIS
  a_we_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(wb.rf_we_wb_o));
  a_no_acc_when_busy : assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb.en_wb_i && !wb.ready_wb_o));
  a_sel_in_range : assert property (@(posedge clk_i) disable iff (rst_i)
    wb.en_wb_i |-> (int'(wb.rf_sel_id_i) < NumRf));
  a_no_stray_resp : assert property (@(posedge clk_i) disable iff (rst_i)
    wb.lsu_resp_valid_i |-> lsu_wait);
`endif

endmodule

// File: tb/tb_cve2_wb_stage.sv
// Directed bench for cve2_wb_stage with a write scoreboard.
module tb_cve2_wb_stage;
  localparam int NumRf = 2, DataWidth = 32, AddrWidth = 5;

  typedef struct packed {
    logic       sel;
    logic [4:0] waddr;
    logic [31:0] wdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  cve2_wb_stage_if #(.NumRf(NumRf), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) bus ();

  cve2_wb_stage #(.NumRf(NumRf), .DataWidth(DataWidth), .AddrWidth(AddrWidth)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .wb   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.en_wb_i = 0; bus.flush_i = 0; bus.instr_lsu_id_i = 0;
    bus.instr_is_compressed_id_i = 0; bus.instr_perf_count_id_i = 0;
    bus.rf_sel_id_i = 0; bus.rf_waddr_id_i = 0; bus.rf_wdata_id_i = 0; bus.rf_we_id_i = 0;
    bus.lsu_resp_valid_i = 0; bus.lsu_resp_err_i = 0; bus.rf_wdata_lsu_i = 0;
  endtask

  // Present an instruction to the stage; push its write if it is expected to land.
  task automatic issue(input logic lsu, input logic sel, input logic [4:0] waddr,
                       input logic [31:0] wdata, input logic comp, input logic expect_write,
                       input logic [31:0] exp_data);
    exp_t e;
    bus.en_wb_i = 1; bus.instr_lsu_id_i = lsu; bus.instr_is_compressed_id_i = comp;
    bus.instr_perf_count_id_i = 1; bus.rf_sel_id_i = sel; bus.rf_waddr_id_i = waddr;
    bus.rf_wdata_id_i = wdata; bus.rf_we_id_i = 1;
    if (expect_write) begin
      e.sel = sel; e.waddr = waddr; e.wdata = exp_data;
      sb.push_back(e);
    end
  endtask

  // Check the write/perf outputs of the current cycle against the scoreboard.
  task automatic sample(input string tag, input logic exp_write, input logic exp_perf,
                        input logic exp_comp);
    exp_t e;
    #1;
    if (exp_write) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk({tag, "_we"},    32'(bus.rf_we_wb_o), 32'(2'b01 << e.sel));
        chk({tag, "_waddr"}, 32'(bus.rf_waddr_wb_o), 32'(e.waddr));
        chk({tag, "_wdata"}, bus.rf_wdata_wb_o, e.wdata);
      end
    end else begin
      chk({tag, "_we_off"},    32'(bus.rf_we_wb_o), 32'd0);
      chk({tag, "_wdata_off"}, bus.rf_wdata_wb_o, 32'd0);
    end
    chk({tag, "_perf"},      32'(bus.perf_instr_ret_wb_o), 32'(exp_perf));
    chk({tag, "_perf_comp"}, 32'(bus.perf_instr_ret_compressed_wb_o), 32'(exp_comp));
  endtask

  initial begin
    idle();
    #12;
    // Reset state
    chk("rst_ready",   32'(bus.ready_wb_o), 32'd1);
    chk("rst_valid",   32'(bus.wb_valid_o), 32'd0);
    chk("rst_pending", 32'(bus.wb_pending_lsu_o), 32'd0);
    sample("rst", 0, 0, 0);
    tick();
    rst = 0;
    tick();

    // Non-LSU back-to-back stream
    issue(0, 0, 5'd5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF);
    sample("s0", 0, 0, 0);
    tick();
    issue(0, 0, 5'd6, 32'hCAFE0006, 1, 1, 32'hCAFE0006);
    chk("s1_valid", 32'(bus.wb_valid_o), 32'd1);
    sample("s1", 1, 1, 0);
    tick();
    // Load issued while the second ALU result retires
    issue(1, 1, 5'd3, 32'h0, 0, 1, 32'h12345678);
    sample("s2", 1, 1, 1);
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      chk("ld_ready_low", 32'(bus.ready_wb_o), 32'd0);
      chk("ld_pending",   32'(bus.wb_pending_lsu_o), 32'd1);
      sample("ld_wait", 0, 0, 0);
      tick();
    end
    bus.lsu_resp_valid_i = 1; bus.rf_wdata_lsu_i = 32'h12345678;
    sample("ld_resp", 1, 1, 0);
    chk("ld_resp_ready", 32'(bus.ready_wb_o), 32'd1);
    chk("ld_wb_sel", 32'(bus.wb_sel_o), 32'd1);
    tick();
    idle();
    chk("ld_empty", 32'(bus.wb_valid_o), 32'd0);

    // LSU bus error
    issue(1, 0, 5'd7, 32'h0, 1, 0, 32'h0);
    tick();
    idle();
    bus.lsu_resp_valid_i = 1; bus.lsu_resp_err_i = 1; bus.rf_wdata_lsu_i = 32'hBAD0BAD0;
    sample("err", 0, 0, 0);
    tick();
    idle();
    chk("err_empty", 32'(bus.wb_valid_o), 32'd0);

    // Flush in WB_FULL
    issue(0, 0, 5'd8, 32'h88, 0, 0, 32'h0);
    tick();
    idle();
    bus.flush_i = 1;
    sample("flush_full", 0, 0, 0);
    tick();
    idle();
    chk("flush_empty", 32'(bus.wb_valid_o), 32'd0);

    // Flush in WB_FULL with a same-cycle accept
    issue(0, 0, 5'd9, 32'h99, 0, 0, 32'h0);
    tick();
    issue(0, 1, 5'd10, 32'hA0A0_000A, 0, 1, 32'hA0A0_000A);
    bus.flush_i = 1;
    sample("flush_acc", 0, 0, 0);
    tick();
    idle();
    sample("flush_acc_wr", 1, 1, 0);
    tick();

    // Flush in WB_WAIT_LSU is ignored
    issue(1, 1, 5'd11, 32'h0, 0, 1, 32'hA5A5_5A5A);
    tick();
    idle();
    bus.flush_i = 1;
    chk("flush_wait_pending", 32'(bus.wb_pending_lsu_o), 32'd1);
    sample("flush_wait", 0, 0, 0);
    tick();
    idle();
    bus.lsu_resp_valid_i = 1; bus.rf_wdata_lsu_i = 32'hA5A5_5A5A;
    sample("flush_wait_resp", 1, 1, 0);
    tick();

    // Response and new accept in the same cycle
    idle();
    issue(1, 0, 5'd12, 32'h0, 0, 1, 32'h1111_0012);
    tick();
    idle();
    issue(0, 1, 5'd13, 32'h0000_0013, 1, 0, 32'h0);
    bus.lsu_resp_valid_i = 1; bus.rf_wdata_lsu_i = 32'h1111_0012;
    begin
      exp_t e;
      e.sel = 1'b1; e.waddr = 5'd13; e.wdata = 32'h0000_0013;
      sb.push_back(e);
    end
    sample("rsp_acc_old", 1, 1, 0);
    tick();
    idle();
    sample("rsp_acc_new", 1, 1, 1);
    tick();
    chk("rsp_acc_empty", 32'(bus.wb_valid_o), 32'd0);

    // Async reset while waiting on the LSU
    issue(1, 0, 5'd14, 32'h0, 0, 0, 32'h0);
    tick();
    idle();
    chk("rw_pending", 32'(bus.wb_pending_lsu_o), 32'd1);
    #2;
    rst = 1;
    #1;
    chk("rw_ready",   32'(bus.ready_wb_o), 32'd1);
    chk("rw_pending0", 32'(bus.wb_pending_lsu_o), 32'd0);
    chk("rw_valid",   32'(bus.wb_valid_o), 32'd0);
    chk("rw_waddr",   32'(bus.rf_waddr_wb_o), 32'd0);
    bus.lsu_resp_valid_i = 1; bus.rf_wdata_lsu_i = 32'h0BADF00D;
    sample("rw_stray", 0, 0, 0);
    tick();
    idle();
    rst = 0;
    tick();
    chk("rw_after", 32'(bus.wb_valid_o), 32'd0);
    sample("rw_after", 0, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end
endmodule
